// File: rtl/control_unit_pkg.sv
// Shared constants and types for the multicycle processor control stage:
// instruction opcodes, step numbers and the per-step control bundle.
package control_unit_pkg;

  localparam int IW_DEF   = 9;
  localparam int NREG_DEF = 8;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;

  // Register selects name the operand field (X or Y) rather than a register.
  typedef struct packed {
    logic rin_x;
    logic rout_x;
    logic rout_y;
    logic din_out;
    logic ain;
    logic gin;
    logic gout;
    logic add_sub;
    logic done;
  } ctrl_t;

endpackage

// File: rtl/dec3to8.sv
// 3-bit index to one-hot decoder with enable; all zeros when disabled.
module dec3to8 #(
  parameter int N = 8
) (
  input  logic [2:0]   idx_i,
  input  logic         en_i,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    // NOTE: default assignment first, so no path through the block leaves the output unassigned (no latch).
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Control stage: latches the instruction at T0, then drives the datapath
// enables for T1..T3 and asks the step counter to clear when done or idle.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int IW   = IW_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [IW-1:0]   DIN,
  input  logic [2:0]      Tstep,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic            AddSub,
  output logic            Done,
  output logic            Clear
);

  logic [IW-1:0]   ir_q, ir_d;
  logic            busy_q, busy_d;
  logic [2:0]      opcode, rx, ry;
  logic            active, is_alu;
  ctrl_t           ctrl;
  logic [NREG-1:0] x_hot, y_hot;

  assign opcode = ir_q[IW-1 -: 3];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
  // Holding Resetn low must silence every enable even before the flops settle.
  assign active = Resetn & busy_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ir_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so each register samples the pre-edge value of every other.
      ir_q   <= ir_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    ir_d   = ir_q;
    busy_d = busy_q;
    if (Tstep == T0) begin
      busy_d = Run;
      if (Run) ir_d = DIN;
    end else if (Tstep > T3 || ctrl.done) begin
      busy_d = 1'b0;
    end
  end

  always_comb begin
    ctrl = '0;
    if (active) begin
      case (Tstep)
        T1: begin
          case (opcode)
            OP_MV: begin
              ctrl.rout_y = 1'b1;
              ctrl.rin_x  = 1'b1;
              ctrl.done   = 1'b1;
            end
            OP_MVI: begin
              ctrl.din_out = 1'b1;
              ctrl.rin_x   = 1'b1;
              ctrl.done    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.rout_x = 1'b1;
              ctrl.ain    = 1'b1;
            end
            default: ctrl.done = 1'b1;
          endcase
        end
        T2: begin
          if (is_alu) begin
            ctrl.rout_y  = 1'b1;
            ctrl.gin     = 1'b1;
            ctrl.add_sub = (opcode == OP_SUB);
          end
        end
        T3: begin
          if (is_alu) begin
            ctrl.gout  = 1'b1;
            ctrl.rin_x = 1'b1;
            ctrl.done  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  dec3to8 #(.N(NREG)) u_dec_x (
    .idx_i    (rx),
    .en_i     (ctrl.rin_x | ctrl.rout_x),
    .onehot_o (x_hot)
  );

  dec3to8 #(.N(NREG)) u_dec_y (
    .idx_i    (ry),
    .en_i     (ctrl.rout_y),
    .onehot_o (y_hot)
  );

  assign Rin    = ctrl.rin_x  ? x_hot : '0;
  assign Rout   = (ctrl.rout_x ? x_hot : '0) | y_hot;
  assign DINout = ctrl.din_out;
  assign Ain    = ctrl.ain;
  assign Gin    = ctrl.gin;
  assign Gout   = ctrl.gout;
  assign AddSub = ctrl.add_sub;
  assign Done   = ctrl.done;
  // busy low at T1..T3 means a stray count (e.g. reset released mid-count).
  assign Clear  = ~Resetn | ctrl.done | ((Tstep == T0) & ~Run) | (Tstep > T3)
                | (~busy_q & (Tstep != T0));

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: models the step counter, queues the expected
// per-cycle outputs as stimulus is driven and compares them on the falling edge.
module tb_control_unit;

  typedef struct packed {
    logic [2:0] tstep;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       addsub;
    logic       done;
    logic       clear;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  e;
  } sb_t;

  logic       Clock = 1'b0;
  logic       Resetn, Run;
  logic [8:0] DIN;
  logic [2:0] Tstep;
  logic [7:0] Rin, Rout;
  logic       DINout, Ain, Gin, Gout, AddSub, Done, Clear;

  logic [2:0] cnt;
  logic       frc_en;
  logic [2:0] frc_val;

  int  n_vec = 0;
  int  n_err = 0;
  sb_t sb_q[$];

  control_unit #(.IW(9), .NREG(8)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .DIN    (DIN),
    .Tstep  (Tstep),
    .Rin    (Rin),
    .Rout   (Rout),
    .DINout (DINout),
    .Ain    (Ain),
    .Gin    (Gin),
    .Gout   (Gout),
    .AddSub (AddSub),
    .Done   (Done),
    .Clear  (Clear)
  );

  always #5 Clock = ~Clock;

  // Step counter model with synchronous clear; a forced value overrides it.
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn)    cnt <= 3'd0;
    else if (Clear) cnt <= 3'd0;
    else            cnt <= cnt + 3'd1;
  end
  assign Tstep = frc_en ? frc_val : cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t mk(input logic [2:0] t, input logic [7:0] rin, input logic [7:0] rout,
                              input logic dinout, input logic ain, input logic gin,
                              input logic gout, input logic addsub, input logic done,
                              input logic clear);
    obs_t o;
    o.tstep  = t;
    o.rin    = rin;
    o.rout   = rout;
    o.dinout = dinout;
    o.ain    = ain;
    o.gin    = gin;
    o.gout   = gout;
    o.addsub = addsub;
    o.done   = done;
    o.clear  = clear;
    return o;
  endfunction

  task automatic step(input string tag, input logic rstn, input logic run, input logic [8:0] din,
                      input logic fe, input logic [2:0] fv, input obs_t e);
    sb_t s;
    @(posedge Clock);
    #1;
    Resetn  = rstn;
    Run     = run;
    DIN     = din;
    frc_en  = fe;
    frc_val = fv;
    s.tag   = tag;
    s.e     = e;
    sb_q.push_back(s);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b1, 1'b0, 9'h000, 1'b0, 3'd0, mk(3'd0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
  endtask

  // Issue one instruction from T0; Run during the later steps is 'hold'.
  task automatic issue(input string tag, input logic [8:0] ir, input logic [8:0] d1, input logic hold);
    logic [2:0] op;
    logic [7:0] xh, yh;
    op = ir[8:6];
    xh = 8'd1 << ir[5:3];
    yh = 8'd1 << ir[2:0];
    step({tag, " T0"}, 1'b1, 1'b1, ir, 1'b0, 3'd0, mk(3'd0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    case (op)
      3'b000: step({tag, " T1"}, 1'b1, hold, 9'h1FF, 1'b0, 3'd0,
                   mk(3'd1, xh, yh, 0, 0, 0, 0, 0, 1, 1));
      3'b001: step({tag, " T1"}, 1'b1, hold, d1, 1'b0, 3'd0,
                   mk(3'd1, xh, 8'h00, 1, 0, 0, 0, 0, 1, 1));
      3'b010, 3'b011: begin
        step({tag, " T1"}, 1'b1, hold, 9'h1FF, 1'b0, 3'd0,
             mk(3'd1, 8'h00, xh, 0, 1, 0, 0, 0, 0, 0));
        step({tag, " T2"}, 1'b1, hold, 9'h1FF, 1'b0, 3'd0,
             mk(3'd2, 8'h00, yh, 0, 0, 1, 0, op[0], 0, 0));
        step({tag, " T3"}, 1'b1, hold, 9'h1FF, 1'b0, 3'd0,
             mk(3'd3, xh, 8'h00, 0, 0, 0, 1, 0, 1, 1));
      end
      default: step({tag, " T1"}, 1'b1, hold, 9'h1FF, 1'b0, 3'd0,
                    mk(3'd1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    endcase
  endtask

  sb_t  cur;
  obs_t obs;
  always @(negedge Clock) begin
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      obs = {Tstep, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Done, Clear};
      check(cur.tag, 32'(obs), 32'(cur.e));
      check({cur.tag, " bus"}, 32'($countones({Rout, DINout, Gout}) <= 1), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Resetn  = 1'b0;
    Run     = 1'b0;
    DIN     = 9'h000;
    frc_en  = 1'b0;
    frc_val = 3'd0;

    step("reset", 1'b0, 1'b0, 9'h000, 1'b0, 3'd0, mk(3'd0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    step("reset run", 1'b0, 1'b1, 9'o150, 1'b0, 3'd0, mk(3'd0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) idle("idle");

    issue("mvi", 9'o150, 9'h0A5, 1'b0);
    idle("mvi after");
    issue("mv", 9'o012, 9'h000, 1'b0);
    idle("mv after");
    issue("sub", 9'o334, 9'h000, 1'b0);
    idle("sub after");
    issue("undef", 9'o645, 9'h000, 1'b0);
    idle("undef after");

    issue("b2b mv", 9'o012, 9'h000, 1'b1);
    issue("b2b add", 9'o245, 9'h000, 1'b1);
    issue("b2b mvi", 9'o170, 9'h155, 1'b1);
    idle("b2b after");

    // Reset asserted at T2 of an add.
    step("rst add T0", 1'b1, 1'b1, 9'o223, 1'b0, 3'd0, mk(3'd0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    step("rst add T1", 1'b1, 1'b0, 9'h000, 1'b0, 3'd0, mk(3'd1, 8'h00, 8'h04, 0, 1, 0, 0, 0, 0, 0));
    step("rst at T2", 1'b0, 1'b1, 9'h000, 1'b0, 3'd0, mk(3'd0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    idle("post rst");
    step("post rst busy0", 1'b1, 1'b1, 9'h000, 1'b1, 3'd2, mk(3'd2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    idle("post rst idle");

    // Illegal step count mid-instruction, then confirm busy was dropped.
    step("ill add T0", 1'b1, 1'b1, 9'o223, 1'b0, 3'd0, mk(3'd0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    step("ill add T1", 1'b1, 1'b0, 9'h000, 1'b0, 3'd0, mk(3'd1, 8'h00, 8'h04, 0, 1, 0, 0, 0, 0, 0));
    step("ill T5", 1'b1, 1'b1, 9'h000, 1'b1, 3'd5, mk(3'd5, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    step("ill T2 after", 1'b1, 1'b0, 9'h000, 1'b1, 3'd2, mk(3'd2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    idle("ill recover");
    step("idle T7", 1'b1, 1'b1, 9'o012, 1'b1, 3'd7, mk(3'd7, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    idle("final");

    @(negedge Clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
